// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// Data port has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   typedef enum logic {S_IDLE, S_BUSY} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

   state_t              state_q, state_d;
   owner_t              owner_q, owner_d;
   logic [CNT_W-1:0]    starve_q, starve_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                if_rvalid_q, if_rvalid_d;
   logic                dm_rvalid_q, dm_rvalid_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
   logic                if_gnt_c, dm_gnt_c;
   logic                at_limit;

   assign at_limit = (starve_q == CNT_W'(STARVE_LIMIT));

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      starve_d    = starve_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rvalid_d = 1'b0;
      dm_rvalid_d = 1'b0;
      if_rdata_d  = '0;
      dm_rdata_d  = '0;
      if_gnt_c    = 1'b0;
      dm_gnt_c    = 1'b0;

      if (!reset) begin
         case (state_q)
            S_IDLE: begin
               if_gnt_c = if_req && (!dm_req || at_limit);
               dm_gnt_c = dm_req && !if_gnt_c;
               if (dm_gnt_c) begin
                  state_d     = S_BUSY;
                  owner_d     = OWN_DM;
                  mem_req_d   = 1'b1;
                  mem_we_d    = dm_we;
                  mem_addr_d  = dm_addr;
                  mem_wdata_d = dm_wdata;
                  // Count only data wins that actually bypassed a waiting fetch.
                  if (!if_req)
                     starve_d = '0;
                  else if (!at_limit)
                     starve_d = starve_q + CNT_W'(1);
               end else if (if_gnt_c) begin
                  state_d     = S_BUSY;
                  owner_d     = OWN_IF;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = '0;
                  starve_d    = '0;
               end
            end
            S_BUSY: begin
               if (mem_ack) begin
                  state_d     = S_IDLE;
                  owner_d     = OWN_NONE;
                  mem_req_d   = 1'b0;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = '0;
                  mem_wdata_d = '0;
                  if (owner_q == OWN_IF) begin
                     if_rvalid_d = 1'b1;
                     if_rdata_d  = mem_we_q ? '0 : mem_rdata;
                  end else if (owner_q == OWN_DM) begin
                     dm_rvalid_d = 1'b1;
                     dm_rdata_d  = mem_we_q ? '0 : mem_rdata;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_NONE;
         starve_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         starve_q    <= starve_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rvalid_q <= if_rvalid_d;
         dm_rvalid_q <= dm_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   assign if_gnt    = if_gnt_c;
   assign dm_gnt    = dm_gnt_c;
   assign if_rvalid = if_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rvalid = dm_rvalid_q;
   assign dm_rdata  = dm_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch/data latency, priority, starvation, writes, reset abort.
// A small memory responder acks after a configurable wait or under manual control.
module tb_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          if_req, dm_req, dm_we;
   logic [AW-1:0] if_addr, dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid;
   logic [DW-1:0] if_rdata, dm_rdata;
   logic          mem_req, mem_we, mem_ack;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   logic          mem_auto  = 1'b1;
   logic          force_ack = 1'b0;
   int unsigned   wait_cfg  = 0;
   logic [DW-1:0] rdata_cfg = '0;
   int unsigned   wcnt;

   int            errors = 0;
   int            checks = 0;
   int            ng;
   logic          exp_if [6];

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(2)) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   initial forever #5 clock = ~clock;

   // Memory responder: acks on the wait_cfg-th cycle of mem_req (0 = first cycle).
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      wcnt      = 0;
      forever begin
         @(posedge clock);
         #2;
         if (!mem_auto) begin
            mem_ack   = force_ack;
            mem_rdata = force_ack ? rdata_cfg : 32'hBAD0BAD0;
            wcnt      = 0;
         end else if (mem_req) begin
            if (wcnt == wait_cfg) begin
               mem_ack   = 1'b1;
               mem_rdata = rdata_cfg;
               wcnt      = 0;
            end else begin
               mem_ack   = 1'b0;
               mem_rdata = 32'hBAD0BAD0;
               wcnt++;
            end
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = 32'hBAD0BAD0;
            wcnt      = 0;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic adv;
      @(posedge clock);
      #1;
   endtask

   task automatic smp;
      @(negedge clock);
   endtask

   initial begin
      exp_if = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      reset = 1'b1; if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      adv; adv;
      smp;
      check("rst_gnt",    {if_gnt, dm_gnt}, 0);
      check("rst_rvalid", {if_rvalid, dm_rvalid}, 0);
      check("rst_rdata",  {if_rdata, dm_rdata}, 0);
      check("rst_mem",    {mem_req, mem_we, mem_addr, mem_wdata}, 0);
      adv;
      reset = 1'b0;

      // Fetch only, three wait cycles
      wait_cfg = 3; rdata_cfg = 32'hDEADBEEF;
      if_req = 1'b1; if_addr = 32'h10;
      smp;
      check("t1_if_gnt", if_gnt, 1);
      check("t1_dm_gnt", dm_gnt, 0);
      check("t1_mreq_pre", mem_req, 0);
      adv;
      if_req = 1'b0; if_addr = '0;
      for (int k = 1; k <= 4; k++) begin
         smp;
         check("t1_mreq", mem_req, 1);
         check("t1_maddr", mem_addr, 32'h10);
         check("t1_mwe", mem_we, 0);
         check("t1_rv_early", if_rvalid, 0);
         check("t1_no_gnt_busy", if_gnt, 0);
         adv;
      end
      smp;
      check("t1_rvalid", if_rvalid, 1);
      check("t1_rdata", if_rdata, 32'hDEADBEEF);
      check("t1_mreq_drop", mem_req, 0);
      check("t1_dm_rv", dm_rvalid, 0);
      adv;
      smp;
      check("t1_rv_pulse", if_rvalid, 0);
      check("t1_rdata_zero", if_rdata, 0);
      adv;

      // Both request together: data first, fetch granted in the dm_rvalid cycle
      wait_cfg = 1; rdata_cfg = 32'h11112222;
      if_req = 1'b1; if_addr = 32'h40;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
      smp;
      check("t2_dm_gnt", dm_gnt, 1);
      check("t2_if_gnt0", if_gnt, 0);
      adv;
      dm_req = 1'b0;
      smp;
      check("t2_maddr_dm", mem_addr, 32'h80);
      check("t2_if_wait1", if_gnt, 0);
      adv;
      smp;
      check("t2_if_wait2", if_gnt, 0);
      check("t2_dm_rv_early", dm_rvalid, 0);
      rdata_cfg = 32'h33334444;
      adv;
      smp;
      check("t2_dm_rvalid", dm_rvalid, 1);
      check("t2_dm_rdata", dm_rdata, 32'h11112222);
      check("t2_if_gnt_same", if_gnt, 1);
      check("t2_if_rv_excl", if_rvalid, 0);
      adv;
      if_req = 1'b0;
      smp;
      check("t2_maddr_if", mem_addr, 32'h40);
      check("t2_dm_rv_pulse", dm_rvalid, 0);
      check("t2_dm_rdata0", dm_rdata, 0);
      adv;
      smp;
      check("t2_if_rv_early", if_rvalid, 0);
      adv;
      smp;
      check("t2_if_rvalid", if_rvalid, 1);
      check("t2_if_rdata", if_rdata, 32'h33334444);
      check("t2_dm_rv_excl", dm_rvalid, 0);
      adv;

      // Write, zero wait; read data returned as 0
      wait_cfg = 0; rdata_cfg = 32'hCAFEF00D;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h55;
      smp;
      check("t4_dm_gnt", dm_gnt, 1);
      adv;
      dm_req = 1'b0; dm_we = 1'b0; dm_wdata = '0;
      smp;
      check("t4_mreq", mem_req, 1);
      check("t4_mwe", mem_we, 1);
      check("t4_maddr", mem_addr, 32'h20);
      check("t4_mwdata", mem_wdata, 32'h55);
      adv;
      smp;
      check("t4_dm_rvalid", dm_rvalid, 1);
      check("t4_dm_rdata0", dm_rdata, 0);
      check("t4_mem_clear", {mem_req, mem_we}, 0);
      adv;

      // Zero-wait back-to-back fetches every two cycles
      rdata_cfg = 32'hA5A5A5A5; if_addr = 32'h100;
      for (int k = 0; k <= 6; k++) begin
         if_req = (k <= 4);
         smp;
         check("t5_gnt", if_gnt, ((k % 2 == 0) && (k <= 4)) ? 1 : 0);
         check("t5_rvalid", if_rvalid, ((k % 2 == 0) && (k >= 2)) ? 1 : 0);
         check("t5_rdata", if_rdata, ((k % 2 == 0) && (k >= 2)) ? 32'hA5A5A5A5 : 0);
         check("t5_mreq", mem_req, (k % 2 == 1) ? 1 : 0);
         adv;
      end
      if_req = 1'b0;

      // Starvation with STARVE_LIMIT=2: D,D,F,D,D,F
      if_req = 1'b1; if_addr = 32'h400;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h800;
      ng = 0;
      for (int c = 0; c < 20 && ng < 6; c++) begin
         smp;
         check("t3_rv_excl", {1'b0, if_rvalid & dm_rvalid}, 0);
         if (if_gnt || dm_gnt) begin
            check("t3_order_is_fetch", if_gnt, exp_if[ng]);
            check("t3_gnt_onehot", {1'b0, if_gnt & dm_gnt}, 0);
            ng++;
         end
         adv;
      end
      check("t3_ngrants", ng, 6);
      if_req = 1'b0; dm_req = 1'b0;
      repeat (3) adv;

      // mem_ack while idle is ignored
      mem_auto = 1'b0; force_ack = 1'b1; rdata_cfg = 32'h77;
      smp;
      adv;
      force_ack = 1'b0;
      smp;
      check("t7_idle_ack_rv", {if_rvalid, dm_rvalid}, 0);
      check("t7_idle_ack_mreq", mem_req, 0);
      adv;

      // Reset while busy, late ack ignored, then normal service
      if_req = 1'b1; if_addr = 32'h200;
      smp;
      check("t6_gnt", if_gnt, 1);
      adv;
      if_req = 1'b0; reset = 1'b1;
      smp;
      check("t6_mreq_busy", mem_req, 1);
      adv;
      reset = 1'b0; force_ack = 1'b1; rdata_cfg = 32'h99;
      smp;
      check("t6_mreq_abort", mem_req, 0);
      check("t6_no_rv1", {if_rvalid, dm_rvalid}, 0);
      adv;
      force_ack = 1'b0;
      smp;
      check("t6_no_rv2", {if_rvalid, dm_rvalid}, 0);
      check("t6_mreq_idle", mem_req, 0);
      adv;
      mem_auto = 1'b1; wait_cfg = 0; rdata_cfg = 32'h12345678;
      if_req = 1'b1; if_addr = 32'h300;
      smp;
      check("t6_regnt", if_gnt, 1);
      adv;
      if_req = 1'b0;
      smp;
      check("t6_remreq", mem_req, 1);
      check("t6_readdr", mem_addr, 32'h300);
      adv;
      smp;
      check("t6_rervalid", if_rvalid, 1);
      check("t6_rerdata", if_rdata, 32'h12345678);
      adv;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
